// File: rtl/cpu_pkg.sv
// Shared CPU definitions: data width, register address width and the
// writeback entry carried through the long-latency result FIFO.
package cpu_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of writeback entries. Besides the head it exposes
// every storage slot and a per-slot valid flag so the owner can build a
// pending-write view of everything still queued.
module wb_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  wb_entry_t         push_entry,
    input  logic              pop,
    output wb_entry_t         head,
    output logic              full,
    output logic              empty,
    output wb_entry_t         entries [DEPTH],
    output logic [DEPTH-1:0]  entry_valid
);

    localparam int AW = $clog2(DEPTH);

    wb_entry_t       mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            do_push;
    logic            do_pop;
    logic [AW-1:0]   off;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];
    assign entries = mem;

    // Storage is not reset; slot validity comes from the pointers and count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // Pointer and occupancy bookkeeping; simultaneous push and pop keep count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // A slot is live when its distance from the read pointer is below count.
    always_comb begin
        off         = '0;
        entry_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off            = AW'(i) - rd_ptr;
            entry_valid[i] = ({1'b0, off} < count);
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the single register-file write port. Port A (execute)
// normally wins; port B (long-latency) results queue in a FIFO and drain when
// A is idle or when the starvation counter forces a one-cycle A stall.
module regfile_wb_arbiter
    import cpu_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    input  logic [4:0]       a_rd,
    input  logic [XLEN-1:0]  a_data,
    output logic             stall_a,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [4:0]       b_rd,
    input  logic [XLEN-1:0]  b_data,
    output logic             wr_en,
    output logic [4:0]       wrr,
    output logic [XLEN-1:0]  wrdata,
    output logic [31:0]      pending_mask
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic             fifo_full;
    logic             fifo_empty;
    logic             push_b;
    logic             pop_b;
    logic             a_xfer;
    wb_entry_t        push_entry;
    wb_entry_t        head;
    wb_entry_t        fifo_entries [DEPTH];
    logic [DEPTH-1:0] fifo_valid;
    logic [SW-1:0]    starve_cnt;

    // b_ready depends only on the registered occupancy, never on b_valid.
    assign b_ready    = !fifo_full;
    assign a_xfer     = a_valid && !stall_a;
    assign push_b     = b_valid && b_ready && (b_rd != '0);
    assign pop_b      = !fifo_empty && (stall_a || !a_xfer);
    assign push_entry = '{rd: b_rd, data: b_data};

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (push_b),
        .push_entry  (push_entry),
        .pop         (pop_b),
        .head        (head),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .entries     (fifo_entries),
        .entry_valid (fifo_valid)
    );

    // Output register, starvation counter and the registered one-cycle stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en      <= 1'b0;
            wrr        <= '0;
            wrdata     <= '0;
            stall_a    <= 1'b0;
            starve_cnt <= '0;
        end else begin
            stall_a <= 1'b0;
            if (a_xfer) begin
                wr_en  <= (a_rd != '0);
                wrr    <= a_rd;
                wrdata <= a_data;
            end else if (pop_b) begin
                // x0 entries are never queued, so a pop always writes.
                wr_en  <= 1'b1;
                wrr    <= head.rd;
                wrdata <= head.data;
            end else begin
                wr_en  <= 1'b0;
            end

            if (pop_b || fifo_empty) begin
                starve_cnt <= '0;
            end else if (a_xfer) begin
                starve_cnt <= starve_cnt + 1'b1;
                if (starve_cnt == SW'(STARVE_LIMIT - 1)) begin
                    stall_a <= 1'b1;
                end
            end
        end
    end

    // Registers with a write still in flight: queued entries plus the output stage.
    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (fifo_valid[i]) begin
                pending_mask[fifo_entries[i].rd] = 1'b1;
            end
        end
        if (wr_en) begin
            pending_mask[wrr] = 1'b1;
        end
        pending_mask[0] = 1'b0;
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a small register-file model
// fed from the write port.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid;
    logic [4:0]  a_rd;
    logic [31:0] a_data;
    logic        stall_a;
    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_rd;
    logic [31:0] b_data;
    logic        wr_en;
    logic [4:0]  wrr;
    logic [31:0] wrdata;
    logic [31:0] pending_mask;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] rf [32];
    logic [4:0]  log_rd  [256];
    logic [31:0] log_dat [256];
    int          wr_count = 0;

    regfile_wb_arbiter #(
        .XLEN         (32),
        .DEPTH        (2),
        .STARVE_LIMIT (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .a_valid      (a_valid),
        .a_rd         (a_rd),
        .a_data       (a_data),
        .stall_a      (stall_a),
        .b_valid      (b_valid),
        .b_ready      (b_ready),
        .b_rd         (b_rd),
        .b_data       (b_data),
        .wr_en        (wr_en),
        .wrr          (wrr),
        .wrdata       (wrdata),
        .pending_mask (pending_mask)
    );

    always #5 clk = ~clk;

    // Log every write and commit it to the register-file model.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            if (wr_count < 256) begin
                log_rd[wr_count]  = wrr;
                log_dat[wr_count] = wrdata;
            end
            wr_count = wr_count + 1;
            if (wrr != 5'd0) rf[wrr] = wrdata;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        a_valid = 1'b1; a_rd = 5'd3; a_data = 32'h11;
        b_valid = 1'b1; b_rd = 5'd4; b_data = 32'h22;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests_run++; if (wr_en !== 1'b0) begin tests_failed++; $display("FAIL reset_wr_en: got %0b expected 0", wr_en); end
        tests_run++; if (wrr !== 5'd0) begin tests_failed++; $display("FAIL reset_wrr: got %0d expected 0", wrr); end
        tests_run++; if (wrdata !== 32'd0) begin tests_failed++; $display("FAIL reset_wrdata: got %h expected 0", wrdata); end
        tests_run++; if (stall_a !== 1'b0) begin tests_failed++; $display("FAIL reset_stall_a: got %0b expected 0", stall_a); end
        tests_run++; if (b_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_b_ready: got %0b expected 1", b_ready); end
        tests_run++; if (pending_mask !== 32'd0) begin tests_failed++; $display("FAIL reset_mask: got %h expected 0", pending_mask); end
        @(posedge clk);
        #1;
        rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
        @(negedge clk);
        tests_run++; if (wr_en !== 1'b0) begin tests_failed++; $display("FAIL reset_release_wr_en: got %0b expected 0", wr_en); end
        tick();
    endtask

    task automatic test_port_a;
        a_valid = 1'b1; a_rd = 5'd5; a_data = 32'hDEADBEEF;
        tick();
        a_valid = 1'b0;
        @(negedge clk);
        tests_run++; if (wr_en !== 1'b1) begin tests_failed++; $display("FAIL a_wr_en: got %0b expected 1", wr_en); end
        tests_run++; if (wrr !== 5'd5) begin tests_failed++; $display("FAIL a_wrr: got %0d expected 5", wrr); end
        tests_run++; if (wrdata !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL a_wrdata: got %h expected deadbeef", wrdata); end
        tests_run++; if (pending_mask !== 32'h20) begin tests_failed++; $display("FAIL a_mask: got %h expected 00000020", pending_mask); end
        tick();
        tick();
        tests_run++; if (rf[5] !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL a_rf_read: got %h expected deadbeef", rf[5]); end
    endtask

    task automatic test_x0;
        int n0;
        n0 = wr_count;
        a_valid = 1'b1; a_rd = 5'd0; a_data = 32'h1234;
        tick();
        a_valid = 1'b0;
        b_valid = 1'b1; b_rd = 5'd0; b_data = 32'h5678;
        @(negedge clk);
        tests_run++; if (wr_en !== 1'b0) begin tests_failed++; $display("FAIL x0_a_wr_en: got %0b expected 0", wr_en); end
        tick();
        b_valid = 1'b0;
        @(negedge clk);
        tests_run++; if (wr_en !== 1'b0) begin tests_failed++; $display("FAIL x0_b_wr_en: got %0b expected 0", wr_en); end
        tests_run++; if (pending_mask !== 32'd0) begin tests_failed++; $display("FAIL x0_mask: got %h expected 0", pending_mask); end
        tick();
        tick();
        tests_run++; if (wr_count != n0) begin tests_failed++; $display("FAIL x0_no_writes: got %0d writes expected 0", wr_count - n0); end
    endtask

    task automatic test_b_latency;
        b_valid = 1'b1; b_rd = 5'd12; b_data = 32'h00C0FFEE;
        tick();
        b_valid = 1'b0;
        @(negedge clk);
        tests_run++; if (wr_en !== 1'b0) begin tests_failed++; $display("FAIL b_lat_early: got %0b expected 0", wr_en); end
        tests_run++; if (pending_mask !== 32'h1000) begin tests_failed++; $display("FAIL b_lat_mask_q: got %h expected 00001000", pending_mask); end
        tick();
        @(negedge clk);
        tests_run++; if (wr_en !== 1'b1 || wrr !== 5'd12 || wrdata !== 32'h00C0FFEE) begin
            tests_failed++; $display("FAIL b_lat_write: got en=%0b rd=%0d data=%h expected en=1 rd=12 data=00c0ffee", wr_en, wrr, wrdata); end
        tests_run++; if (pending_mask !== 32'h1000) begin tests_failed++; $display("FAIL b_lat_mask_wr: got %h expected 00001000", pending_mask); end
        tick();
    endtask

    task automatic test_starvation;
        int n0, ai, stall_cnt, stall_at;
        logic s;
        logic [4:0]  exp_rd;
        logic [31:0] exp_dat;
        n0 = wr_count;
        b_valid = 1'b1; b_rd = 5'd7; b_data = 32'hA5; a_valid = 1'b0;
        tick();
        b_valid = 1'b0;
        ai = 0; stall_cnt = 0; stall_at = -1;
        for (int cyc = 0; cyc < 40 && ai < 10; cyc++) begin
            a_valid = 1'b1; a_rd = 5'(ai + 1); a_data = 32'h100 + 32'(ai + 1);
            @(negedge clk);
            s = stall_a;
            if (cyc == 0) begin
                tests_run++; if (pending_mask !== 32'h80) begin tests_failed++; $display("FAIL starve_mask_q: got %h expected 00000080", pending_mask); end
            end
            if (s) begin stall_cnt++; stall_at = ai; end
            @(posedge clk);
            #1;
            if (!s) ai++;
        end
        a_valid = 1'b0;
        tests_run++; if (ai != 10) begin tests_failed++; $display("FAIL starve_timeout: got %0d accepted expected 10", ai); end
        tick();
        tick();
        tests_run++; if (stall_cnt != 1) begin tests_failed++; $display("FAIL starve_stall_cycles: got %0d expected 1", stall_cnt); end
        tests_run++; if (stall_at != 4) begin tests_failed++; $display("FAIL starve_stall_point: got %0d expected 4", stall_at); end
        tests_run++; if (wr_count - n0 != 11) begin tests_failed++; $display("FAIL starve_write_count: got %0d expected 11", wr_count - n0); end
        for (int k = 0; k < 11; k++) begin
            if (k < 4)       begin exp_rd = 5'(k + 1); exp_dat = 32'h100 + 32'(k + 1); end
            else if (k == 4) begin exp_rd = 5'd7;      exp_dat = 32'hA5; end
            else             begin exp_rd = 5'(k);     exp_dat = 32'h100 + 32'(k); end
            tests_run++;
            if (log_rd[n0 + k] !== exp_rd || log_dat[n0 + k] !== exp_dat) begin
                tests_failed++;
                $display("FAIL starve_order[%0d]: got rd=%0d data=%h expected rd=%0d data=%h", k, log_rd[n0 + k], log_dat[n0 + k], exp_rd, exp_dat);
            end
        end
    endtask

    task automatic test_full_fifo;
        logic [4:0]  b_rd_tab  [3];
        logic [31:0] b_dat_tab [3];
        int n0, ai, bi, a_seen, b_seen;
        logic s, r;
        b_rd_tab  = '{5'd3, 5'd4, 5'd6};
        b_dat_tab = '{32'd1, 32'd2, 32'd3};
        n0 = wr_count; ai = 0; bi = 0;
        for (int cyc = 0; cyc < 80 && (ai < 12 || bi < 3); cyc++) begin
            a_valid = (ai < 12); a_rd = 5'(20 + ai); a_data = 32'h200 + 32'(ai);
            b_valid = (bi < 3);
            b_rd    = (bi < 3) ? b_rd_tab[bi]  : 5'd0;
            b_data  = (bi < 3) ? b_dat_tab[bi] : 32'd0;
            @(negedge clk);
            s = stall_a; r = b_ready;
            if (cyc == 2) begin
                tests_run++; if (r !== 1'b0 || bi != 2) begin tests_failed++; $display("FAIL full_ready_fall: got ready=%0b pushes=%0d expected ready=0 pushes=2", r, bi); end
                tests_run++; if (pending_mask !== 32'h0020_0018) begin tests_failed++; $display("FAIL full_mask_q: got %h expected 00200018", pending_mask); end
            end
            if (cyc == 5) begin
                tests_run++; if (s !== 1'b1 || r !== 1'b0) begin tests_failed++; $display("FAIL full_pop_cycle: got stall=%0b ready=%0b expected stall=1 ready=0", s, r); end
            end
            if (cyc == 6) begin
                tests_run++; if (s !== 1'b0 || r !== 1'b1) begin tests_failed++; $display("FAIL full_ready_rise: got stall=%0b ready=%0b expected stall=0 ready=1", s, r); end
                tests_run++; if (pending_mask !== 32'h18) begin tests_failed++; $display("FAIL full_mask_pop: got %h expected 00000018", pending_mask); end
            end
            @(posedge clk);
            #1;
            if (a_valid && !s) ai++;
            if (b_valid && r)  bi++;
        end
        a_valid = 1'b0; b_valid = 1'b0;
        tests_run++; if (ai != 12 || bi != 3) begin tests_failed++; $display("FAIL full_timeout: got a=%0d b=%0d expected a=12 b=3", ai, bi); end
        repeat (4) tick();
        tests_run++; if (pending_mask !== 32'd0) begin tests_failed++; $display("FAIL full_mask_drained: got %h expected 0", pending_mask); end
        a_seen = 0; b_seen = 0;
        for (int k = n0; k < wr_count && k < 256; k++) begin
            tests_run++;
            if (log_rd[k] >= 5'd20) begin
                if (log_rd[k] !== 5'(20 + a_seen) || log_dat[k] !== 32'h200 + 32'(a_seen)) begin
                    tests_failed++; $display("FAIL full_a_order[%0d]: got rd=%0d data=%h expected rd=%0d", a_seen, log_rd[k], log_dat[k], 20 + a_seen);
                end
                a_seen++;
            end else begin
                if (b_seen >= 3 || log_rd[k] !== b_rd_tab[b_seen % 3] || log_dat[k] !== b_dat_tab[b_seen % 3]) begin
                    tests_failed++; $display("FAIL full_b_order[%0d]: got rd=%0d data=%h", b_seen, log_rd[k], log_dat[k]);
                end
                b_seen++;
            end
        end
        tests_run++; if (a_seen != 12 || b_seen != 3) begin tests_failed++; $display("FAIL full_counts: got a=%0d b=%0d expected a=12 b=3", a_seen, b_seen); end
    endtask

    task automatic test_reset_mid_queue;
        int n0;
        n0 = wr_count;
        a_valid = 1'b1; a_rd = 5'd0; a_data = 32'h77;
        b_valid = 1'b1; b_rd = 5'd8; b_data = 32'h88;
        tick();
        b_rd = 5'd9; b_data = 32'h99;
        tick();
        b_valid = 1'b0;
        @(negedge clk);
        tests_run++; if (pending_mask !== 32'h300 || b_ready !== 1'b0) begin
            tests_failed++; $display("FAIL rstq_queued: got mask=%h ready=%0b expected mask=00000300 ready=0", pending_mask, b_ready); end
        @(posedge clk);
        #1;
        rst = 1'b1; a_valid = 1'b0;
        tick();
        rst = 1'b0;
        @(negedge clk);
        tests_run++; if (pending_mask !== 32'd0) begin tests_failed++; $display("FAIL rstq_mask: got %h expected 0", pending_mask); end
        tests_run++; if (b_ready !== 1'b1) begin tests_failed++; $display("FAIL rstq_ready: got %0b expected 1", b_ready); end
        repeat (6) tick();
        tests_run++; if (wr_count != n0) begin tests_failed++; $display("FAIL rstq_no_writes: got %0d writes expected 0", wr_count - n0); end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        test_reset();
        test_port_a();
        test_x0();
        test_b_latency();
        test_starvation();
        test_full_fifo();
        test_reset_mid_queue();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
